ram32m_burst_reader: RTL and testbench

RAM32M_BURST_READER -- requirements
Module: ram32m_burst_reader

---
 rtl/ram32m_burst_reader.sv | 107 ++++++++++
 tb/tb_ram32m_burst_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32m_burst_reader.sv
// Streams LEN+1 RAM32M words from BASE; first word valid one edge after START, then one word per edge.
// Valid/ready output: a stalled word holds data and LAST until accepted; ABORT drops the burst immediately.
module ram32m_burst_reader #(
   parameter logic IS_CLK_INVERTED = 1'b0
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic [4:0] BASE,
   input  logic [4:0] LEN,
   output logic [4:0] ADDR,
   input  logic [1:0] DOA,
   input  logic [1:0] DOB,
   input  logic [1:0] DOC,
   output logic [5:0] M_DATA,
   output logic       M_VALID,
   input  logic       M_READY,
   output logic       M_LAST,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t     state, state_nxt;
   logic [4:0] cnt, cnt_nxt, addr_nxt;
   logic [5:0] data_nxt;
   logic       valid_nxt, last_nxt, done_nxt;
   logic       load;
   logic       clk_eff;

   // Same edge selection as the RAM32M primitive's own clock inversion.
   assign clk_eff = CLK ^ IS_CLK_INVERTED;
   assign load    = !M_VALID || M_READY;
   assign BUSY    = (state != IDLE);

   always_ff @(posedge clk_eff or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         ADDR    <= 5'd0;
         cnt     <= 5'd0;
         M_DATA  <= 6'd0;
         M_VALID <= 1'b0;
         M_LAST  <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ADDR    <= addr_nxt;
         cnt     <= cnt_nxt;
         M_DATA  <= data_nxt;
         M_VALID <= valid_nxt;
         M_LAST  <= last_nxt;
         DONE    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = ADDR;
      cnt_nxt   = cnt;
      data_nxt  = M_DATA;
      valid_nxt = M_VALID;
      last_nxt  = M_LAST;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               addr_nxt  = BASE;
               cnt_nxt   = LEN;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (ABORT) begin
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               cnt_nxt   = 5'd0;
               state_nxt = IDLE;
            end else if (load) begin
               // DO is the asynchronous read of the current ADDR, captured before any same-edge write.
               data_nxt  = {DOC, DOB, DOA};
               valid_nxt = 1'b1;
               last_nxt  = (cnt == 5'd0);
               addr_nxt  = ADDR + 5'd1;
               cnt_nxt   = cnt - 5'd1;
               if (cnt == 5'd0) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (ABORT) begin
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               cnt_nxt   = 5'd0;
               state_nxt = IDLE;
            end else if (M_VALID && M_READY) begin
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram32m_burst_reader.sv
// Directed bench for ram32m_burst_reader with a behavioural RAM32M read model.
module tb_ram32m_burst_reader;

   logic       CLK;
   logic       RST_N;
   logic       START;
   logic       ABORT;
   logic [4:0] BASE;
   logic [4:0] LEN;
   logic [4:0] ADDR;
   logic [1:0] DOA, DOB, DOC;
   logic [5:0] M_DATA;
   logic       M_VALID;
   logic       M_READY;
   logic       M_LAST;
   logic       BUSY;
   logic       DONE;

   logic [1:0] ram_a [32];
   logic [1:0] ram_b [32];
   logic [1:0] ram_c [32];

   int checks = 0;
   int errors = 0;

   ram32m_burst_reader #(.IS_CLK_INVERTED(1'b0)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
      .BASE(BASE), .LEN(LEN), .ADDR(ADDR),
      .DOA(DOA), .DOB(DOB), .DOC(DOC),
      .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST),
      .BUSY(BUSY), .DONE(DONE)
   );

   assign DOA = ram_a[ADDR];
   assign DOB = ram_b[ADDR];
   assign DOC = ram_c[ADDR];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_e4();
      logic [63:0] ia;
      ia = 64'hE4;
      for (int i = 0; i < 32; i++) begin
         ram_a[i] = ia[2*i +: 2];
         ram_b[i] = 2'd0;
         ram_c[i] = 2'd0;
      end
   endtask

   // Contents chosen so that each word read equals its own address.
   task automatic load_pattern();
      for (int i = 0; i < 32; i++) begin
         logic [4:0] a;
         a = 5'(i);
         ram_a[i] = a[1:0];
         ram_b[i] = a[3:2];
         ram_c[i] = {1'b0, a[4]};
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; BASE = 5'd0; LEN = 5'd0; M_READY = 1'b0;
      load_e4();
      #3;
      checks++;
      if ({ADDR, M_DATA, M_VALID, M_LAST, BUSY, DONE} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {ADDR, M_DATA, M_VALID, M_LAST, BUSY, DONE});
      end
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      checks++;
      if (BUSY !== 1'b0 || M_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b valid=%b want 0 0", BUSY, M_VALID);
      end
   endtask

   task automatic test_basic();
      load_e4();
      BASE = 5'd0; LEN = 5'd3; M_READY = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || M_VALID !== 1'b0 || ADDR !== 5'd0) begin
         errors++;
         $display("FAIL basic_start busy=%b valid=%b addr=%0d want 1 0 0", BUSY, M_VALID, ADDR);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (M_VALID !== 1'b1 || M_DATA !== 6'(k) || M_LAST !== (k == 3) || DONE !== 1'b0) begin
            errors++;
            $display("FAIL basic_word%0d valid=%b data=%0d last=%b done=%b want 1 %0d %b 0",
                     k, M_VALID, M_DATA, M_LAST, DONE, k, (k == 3));
         end
      end
      tick();
      checks++;
      if (M_VALID !== 1'b0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL basic_done valid=%b done=%b busy=%b want 0 1 0", M_VALID, DONE, BUSY);
      end
      tick();
      checks++;
      if (DONE !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse done=%b want 0", DONE);
      end
   endtask

   // Ends in the DONE cycle so the next task can issue START there.
   task automatic test_wrap();
      logic [4:0] exp_addr [4];
      exp_addr[0] = 5'd30; exp_addr[1] = 5'd31; exp_addr[2] = 5'd0; exp_addr[3] = 5'd1;
      load_pattern();
      BASE = 5'd30; LEN = 5'd3; M_READY = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ADDR !== exp_addr[k]) begin
            errors++;
            $display("FAIL wrap_addr%0d got %0d want %0d", k, ADDR, exp_addr[k]);
         end
         tick();
         checks++;
         if (M_VALID !== 1'b1 || M_DATA !== {1'b0, exp_addr[k]} || M_LAST !== (k == 3)) begin
            errors++;
            $display("FAIL wrap_word%0d valid=%b data=%0d last=%b want 1 %0d %b",
                     k, M_VALID, M_DATA, M_LAST, exp_addr[k], (k == 3));
         end
      end
      tick();
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL wrap_done done=%b busy=%b want 1 0", DONE, BUSY);
      end
   endtask

   task automatic test_back_to_back();
      BASE = 5'd0; LEN = 5'd0; START = 1'b1;
      tick();
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || ADDR !== 5'd0 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start busy=%b addr=%0d done=%b want 1 0 0", BUSY, ADDR, DONE);
      end
      tick();
      checks++;
      if (M_VALID !== 1'b1 || M_DATA !== 6'd0 || M_LAST !== 1'b1) begin
         errors++;
         $display("FAIL b2b_word valid=%b data=%0d last=%b want 1 0 1", M_VALID, M_DATA, M_LAST);
      end
      tick();
      checks++;
      if (DONE !== 1'b1 || M_VALID !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done done=%b valid=%b want 1 0", DONE, M_VALID);
      end
      tick();
   endtask

   task automatic test_stall();
      int rdy_pat [6] = '{1, 0, 0, 1, 0, 1};
      int exp_dat [6] = '{8, 9, 9, 9, 10, 10};
      int exp_lst [6] = '{0, 0, 0, 0, 1, 1};
      load_pattern();
      BASE = 5'd8; LEN = 5'd2; M_READY = 1'b0; START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      for (int c = 0; c < 6; c++) begin
         M_READY = rdy_pat[c][0];
         checks++;
         if (M_VALID !== 1'b1 || M_DATA !== 6'(exp_dat[c]) || M_LAST !== exp_lst[c][0] || DONE !== 1'b0) begin
            errors++;
            $display("FAIL stall_cyc%0d valid=%b data=%0d last=%b done=%b want 1 %0d %0d 0",
                     c, M_VALID, M_DATA, M_LAST, DONE, exp_dat[c], exp_lst[c]);
         end
         tick();
      end
      checks++;
      if (DONE !== 1'b1 || M_VALID !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL stall_done done=%b valid=%b busy=%b want 1 0 0", DONE, M_VALID, BUSY);
      end
      M_READY = 1'b1;
      tick();
   endtask

   task automatic test_busy_start();
      load_pattern();
      BASE = 5'd16; LEN = 5'd2; M_READY = 1'b1; START = 1'b1;
      tick();
      BASE = 5'd5; LEN = 5'd0;
      tick();
      START = 1'b0;
      checks++;
      if (M_DATA !== 6'd16 || ADDR !== 5'd17 || M_LAST !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_w0 data=%0d addr=%0d last=%b want 16 17 0", M_DATA, ADDR, M_LAST);
      end
      tick();
      checks++;
      if (M_DATA !== 6'd17 || M_LAST !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_w1 data=%0d last=%b want 17 0", M_DATA, M_LAST);
      end
      tick();
      checks++;
      if (M_DATA !== 6'd18 || M_LAST !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_w2 data=%0d last=%b want 18 1", M_DATA, M_LAST);
      end
      tick();
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || ADDR !== 5'd19) begin
         errors++;
         $display("FAIL busy_start_done done=%b busy=%b addr=%0d want 1 0 19", DONE, BUSY, ADDR);
      end
      tick();
   endtask

   task automatic test_abort();
      load_pattern();
      BASE = 5'd4; LEN = 5'd0; M_READY = 1'b0; START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      checks++;
      if (M_VALID !== 1'b1 || M_LAST !== 1'b1 || M_DATA !== 6'd4) begin
         errors++;
         $display("FAIL abort_flush_word valid=%b last=%b data=%0d want 1 1 4", M_VALID, M_LAST, M_DATA);
      end
      ABORT = 1'b1; M_READY = 1'b1;
      tick();
      ABORT = 1'b0;
      checks++;
      if (M_VALID !== 1'b0 || M_LAST !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL abort_flush valid=%b last=%b done=%b busy=%b want 0 0 0 0", M_VALID, M_LAST, DONE, BUSY);
      end
      tick();
      checks++;
      if (DONE !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done done=%b want 0", DONE);
      end
      // ABORT in IDLE is ignored; held into RUN it cancels before any word.
      ABORT = 1'b1; START = 1'b1; BASE = 5'd2; LEN = 5'd3;
      tick();
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || ADDR !== 5'd2) begin
         errors++;
         $display("FAIL abort_idle busy=%b addr=%0d want 1 2", BUSY, ADDR);
      end
      tick();
      ABORT = 1'b0;
      checks++;
      if (BUSY !== 1'b0 || M_VALID !== 1'b0 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL abort_run busy=%b valid=%b done=%b want 0 0 0", BUSY, M_VALID, DONE);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      load_pattern();
      BASE = 5'd0; LEN = 5'd5; M_READY = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      checks++;
      if (M_DATA !== 6'd1 || M_VALID !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_word1 data=%0d valid=%b want 1 1", M_DATA, M_VALID);
      end
      RST_N = 1'b0;
      #2;
      checks++;
      if ({ADDR, M_DATA, M_VALID, M_LAST, BUSY, DONE} !== 15'd0) begin
         errors++;
         $display("FAIL rstmid_async got %h want 0", {ADDR, M_DATA, M_VALID, M_LAST, BUSY, DONE});
      end
      tick();
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_hold done=%b busy=%b want 0 0", DONE, BUSY);
      end
      RST_N = 1'b1; START = 1'b1; BASE = 5'd20; LEN = 5'd1;
      tick();
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || ADDR !== 5'd20) begin
         errors++;
         $display("FAIL rstmid_restart busy=%b addr=%0d want 1 20", BUSY, ADDR);
      end
      tick();
      checks++;
      if (M_DATA !== 6'd20 || M_LAST !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_w0 data=%0d last=%b want 20 0", M_DATA, M_LAST);
      end
      tick();
      checks++;
      if (M_DATA !== 6'd21 || M_LAST !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_w1 data=%0d last=%b want 21 1", M_DATA, M_LAST);
      end
      tick();
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_done done=%b busy=%b want 1 0", DONE, BUSY);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_busy_start();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
